pll_lock_reset_sequencer: RTL and testbench
===========================================

// Module: pll_lock_reset_sequencer
// PURPOSE
//  Parametrised supervisor for a fabric CCC/PLL: powers up the PLL, qualifies LOCK, enables up to 4 outputs,
//  then releases per-domain resets in order 0..NUM_OUT-1. On lock loss it re-asserts all resets and re-sequences.
//  Retries a failed lock (timeout) up to MAX_RETRIES times, then latches FAULT. Sits beside the CCC wrapper,
//  clocked by the PLL reference clock, and feeds domain resets to the video/H.264 pipeline.
// PARAMETERS
//  NUM_OUT            4      number of PLL outputs / reset domains (1..4)
//  PD_CYCLES          16     cycles PLL_POWERDOWN_N held low per attempt (>=1)
//  LOCK_TIMEOUT       65535  cycles to wait for synced lock before retry (>=1)
//  LOCK_FILTER        1024   consecutive synced-lock-high cycles required to qualify lock (>=1)
//  RELEASE_GAP        64     cycles between successive domain reset releases (>=1)
//  MAX_RETRIES        3      timed-out attempts allowed before FAULT (0 = FAULT on first timeout)
//  CNT_W              17     width of the shared down-counter; must hold max(all cycle parameters)
// PORTS
//  REF_CLK            in   1        PLL reference clock; sole clock of the block
//  RESET              in   1        synchronous, active-high reset
//  PLL_LOCK           in   1        raw PLL LOCK (asynchronous to REF_CLK)
//  OUT_EN_MASK        in   NUM_OUT  static: which outputs are used; masked domains stay in reset, OUT_EN=0
//  CLEAR_FAULT        in   1        1-cycle pulse: leave FAULT, clear retry count, restart at POWERDOWN
//  PLL_POWERDOWN_N    out  1        to PLL POWERDOWN_N
//  PLL_OUT_EN         out  NUM_OUT  to PLL OUTn_EN
//  DOMAIN_RESET       out  NUM_OUT  active-high synchronous resets, one per output domain
//  READY              out  1        1 in RUN only
//  LOCK_LOST          out  1        1-cycle pulse per lock-loss event after lock was qualified
//  FAULT              out  1        1 in FAULT state
//  LOSS_COUNT         out  8        lock-loss events since RESET, saturates at 255
// BEHAVIOUR
//  Reset values: PLL_POWERDOWN_N=0, PLL_OUT_EN=0, DOMAIN_RESET=all 1, READY=0, LOCK_LOST=0, FAULT=0, LOSS_COUNT=0;
//   state=POWERDOWN, counter=PD_CYCLES-1, retries=0. All outputs registered.
//  PLL_LOCK passes a 2-flop synchronizer -> lock_s (2-cycle latency); only lock_s is used.
//  States / transitions (one shared down-counter, reloaded on every state entry):
//   POWERDOWN : POWERDOWN_N=0; after PD_CYCLES cycles -> WAIT_LOCK (load LOCK_TIMEOUT-1).
//   WAIT_LOCK : POWERDOWN_N=1; lock_s=1 -> FILTER (load LOCK_FILTER-1). Counter hits 0 with lock_s=0:
//               retries==MAX_RETRIES -> FAULT, else retries++ -> POWERDOWN.
//   FILTER    : lock_s=0 -> WAIT_LOCK (timeout reloaded, no retry charged). LOCK_FILTER consecutive highs -> ENABLE.
//   ENABLE    : PLL_OUT_EN<=OUT_EN_MASK; wait RELEASE_GAP cycles -> RELEASE (idx=0).
//   RELEASE   : on each gap expiry deassert DOMAIN_RESET[idx] if OUT_EN_MASK[idx], idx++; masked idx skipped in
//               the same cycle without consuming a gap. After idx=NUM_OUT-1 handled -> RUN. Mask all-0 -> RUN directly.
//   RUN       : READY=1; holds while lock_s=1.
//   FAULT     : POWERDOWN_N=0, OUT_EN=0, resets asserted; exits only on CLEAR_FAULT or RESET.
//  Lock loss (lock_s=0 in ENABLE, RELEASE or RUN): next edge -> DOMAIN_RESET=all 1, OUT_EN=0, READY=0,
//   LOCK_LOST pulse, LOSS_COUNT+1 (sat), state -> WAIT_LOCK; retries cleared. Latency PLL_LOCK fall -> resets = 3 cycles.
//   PLL stays powered; no powerdown cycle on lock loss.
//  Glitch: a lock_s low lasting 1 cycle in FILTER restarts qualification; in ENABLE/RELEASE/RUN it is a full loss.
//  Simultaneous: RESET dominates all. CLEAR_FAULT outside FAULT ignored. Lock loss beats a release in the same cycle.
//  Reset mid-sequence: everything returns to reset values in one cycle, released domains re-asserted.
// STRUCTURE
//  Package pll_seq_pkg: state enum (POWERDOWN, WAIT_LOCK, FILTER, ENABLE, RELEASE, RUN, FAULT), LOSS_W=8,
//   MAX_OUT=4 constant. One sub-module: pll_lock_sync (2-flop synchronizer, reset value 0). Rest is one FSM + counter.
// TESTING  (PD=4, TIMEOUT=20, FILTER=8, GAP=3, MAX_RETRIES=1, NUM_OUT=4 unless noted)
//  1 Lock rises 5 cycles after POWERDOWN_N=1, held -> READY after FILTER+4*GAP cycles; resets fall at 3-cycle spacing 0..3.
//  2 Lock never rises -> 2 powerdown pulses of 4 cycles, then FAULT=1, POWERDOWN_N=0; CLEAR_FAULT -> POWERDOWN restarts.
//  3 In RUN drop PLL_LOCK 1 cycle -> 3 cycles later all DOMAIN_RESET=1, LOCK_LOST 1-cycle, LOSS_COUNT=1, re-sequence.
//  4 Lock chatters in FILTER (low 1 cycle at filter count 5) -> qualification restarts; no retry charged, no FAULT.
//  5 OUT_EN_MASK=4'b1010 -> OUT_EN=1010, only resets 1 and 3 released, 3 cycles apart; resets 0,2 stay 1.
//  6 RESET asserted in RELEASE after 2 domains released -> next cycle all reset values; 256 losses -> LOSS_COUNT=255.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared types and constants for the PLL lock/reset sequencer
//
// Purpose: sequencer state encoding, loss-counter width, the largest supported
// number of PLL outputs, and a lowest-set-bit helper used to pick the next
// reset domain to release.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_POWERDOWN,
    ST_WAIT_LOCK,
    ST_FILTER,
    ST_ENABLE,
    ST_RELEASE,
    ST_RUN,
    ST_FAULT
  } state_e;

  localparam int LOSS_W  = 8;
  localparam int MAX_OUT = 4;

  // One-hot of the lowest set bit (all zero when v is zero).
  function automatic logic [MAX_OUT-1:0] lowest_set(input logic [MAX_OUT-1:0] v);
    return v & (~v + MAX_OUT'(1));
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// rtl/pll_lock_sync.sv - two-flop synchronizer for the raw PLL lock signal
//
// Purpose: bring the asynchronous PLL LOCK into the reference clock domain.
// Ports:
//   clk_i  in  reference clock
//   rst_i  in  synchronous active-high reset, both flops clear to 0
//   d_i    in  raw asynchronous input
//   q_o    out synchronized output, two cycles of latency
module pll_lock_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_reset_sequencer.sv
// rtl/pll_lock_reset_sequencer.sv - PLL power-up, lock qualification and ordered domain reset release
//
// Purpose: powers the PLL up, qualifies lock, enables the used outputs, then
// releases the per-domain resets in index order. A lock loss re-asserts all
// resets and re-sequences without powering down; repeated lock timeouts end
// in a latched fault that only clear_fault_i or reset_i leaves.
// Ports:
//   ref_clk_i          in  PLL reference clock, sole clock
//   reset_i            in  synchronous active-high reset
//   pll_lock_i         in  raw PLL LOCK (asynchronous)
//   out_en_mask_i      in  static mask of used outputs / domains
//   clear_fault_i      in  single-cycle pulse, leaves the fault state
//   pll_powerdown_n_o  out PLL POWERDOWN_N
//   pll_out_en_o       out PLL output enables
//   domain_reset_o     out active-high per-domain resets
//   ready_o            out high while running
//   lock_lost_o        out single-cycle pulse per lock-loss event
//   fault_o            out high in the fault state
//   loss_count_o       out saturating lock-loss event count
module pll_lock_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_OUT      = 4,
  parameter int PD_CYCLES    = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int LOCK_FILTER  = 1024,
  parameter int RELEASE_GAP  = 64,
  parameter int MAX_RETRIES  = 3,
  parameter int CNT_W        = 17
) (
  input  logic              ref_clk_i,
  input  logic              reset_i,
  input  logic              pll_lock_i,
  input  logic [NUM_OUT-1:0] out_en_mask_i,
  input  logic              clear_fault_i,
  output logic              pll_powerdown_n_o,
  output logic [NUM_OUT-1:0] pll_out_en_o,
  output logic [NUM_OUT-1:0] domain_reset_o,
  output logic              ready_o,
  output logic              lock_lost_o,
  output logic              fault_o,
  output logic [LOSS_W-1:0] loss_count_o
);

  localparam int RET_W = $clog2(MAX_RETRIES + 2);

  logic lock_s;

  pll_lock_sync u_lock_sync (
    .clk_i (ref_clk_i),
    .rst_i (reset_i),
    .d_i   (pll_lock_i),
    .q_o   (lock_s)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RET_W-1:0]   ret_q, ret_d;
  // Domains still waiting for release; the lowest set bit goes next, so
  // masked indices are skipped without spending a gap.
  logic [NUM_OUT-1:0] rem_q, rem_d;
  logic [NUM_OUT-1:0] pick;
  logic [NUM_OUT-1:0] rst_q, rst_d;
  logic [NUM_OUT-1:0] en_q, en_d;
  logic               pd_n_q, pd_n_d;
  logic               ready_q, ready_d;
  logic               lost_q, lost_d;
  logic               fault_q, fault_d;
  logic [LOSS_W-1:0]  loss_q, loss_d;
  logic               loss_evt;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ret_d    = ret_q;
    rem_d    = rem_q;
    rst_d    = rst_q;
    loss_d   = loss_q;
    lost_d   = 1'b0;
    loss_evt = 1'b0;
    pick     = NUM_OUT'(lowest_set(MAX_OUT'(rem_q)));

    case (state_q)
      ST_POWERDOWN: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = CNT_W'(LOCK_TIMEOUT - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_FILTER;
          cnt_d   = CNT_W'(LOCK_FILTER - 1);
        end else if (cnt_q == '0) begin
          if (ret_q == RET_W'(MAX_RETRIES)) begin
            state_d = ST_FAULT;
          end else begin
            ret_d   = ret_q + RET_W'(1);
            state_d = ST_POWERDOWN;
            cnt_d   = CNT_W'(PD_CYCLES - 1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FILTER: begin
        if (!lock_s) begin
          // A single low restarts qualification; not a retry.
          state_d = ST_WAIT_LOCK;
          cnt_d   = CNT_W'(LOCK_TIMEOUT - 1);
        end else if (cnt_q == '0) begin
          state_d = ST_ENABLE;
          cnt_d   = CNT_W'(RELEASE_GAP - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ENABLE: begin
        if (!lock_s) begin
          loss_evt = 1'b1;
        end else if (cnt_q == '0) begin
          // The enable wait is the gap before domain 0; release starts at once.
          state_d = (out_en_mask_i == '0) ? ST_RUN : ST_RELEASE;
          cnt_d   = '0;
          rem_d   = out_en_mask_i;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!lock_s) begin
          loss_evt = 1'b1;
        end else if (cnt_q == '0) begin
          rst_d = rst_q & ~pick;
          rem_d = rem_q & ~pick;
          if ((rem_q & ~pick) == '0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = CNT_W'(RELEASE_GAP - 1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) loss_evt = 1'b1;
      end
      ST_FAULT: begin
        if (clear_fault_i) begin
          state_d = ST_POWERDOWN;
          cnt_d   = CNT_W'(PD_CYCLES - 1);
          ret_d   = '0;
        end
      end
      default: begin
        state_d = ST_POWERDOWN;
        cnt_d   = CNT_W'(PD_CYCLES - 1);
      end
    endcase

    // Lock loss keeps the PLL powered and goes straight back to waiting.
    if (loss_evt) begin
      state_d = ST_WAIT_LOCK;
      cnt_d   = CNT_W'(LOCK_TIMEOUT - 1);
      ret_d   = '0;
      lost_d  = 1'b1;
      if (loss_q != '1) loss_d = loss_q + LOSS_W'(1);
    end

    // Outputs are registered versions of what the next state implies.
    if (!(state_d == ST_RELEASE || state_d == ST_RUN)) rst_d = '1;
    pd_n_d  = !(state_d == ST_POWERDOWN || state_d == ST_FAULT);
    en_d    = (state_d == ST_ENABLE || state_d == ST_RELEASE || state_d == ST_RUN)
              ? out_en_mask_i : '0;
    ready_d = (state_d == ST_RUN);
    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge ref_clk_i) begin
    if (reset_i) begin
      state_q <= ST_POWERDOWN;
      cnt_q   <= CNT_W'(PD_CYCLES - 1);
      ret_q   <= '0;
      rem_q   <= '0;
      rst_q   <= '1;
      en_q    <= '0;
      pd_n_q  <= 1'b0;
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
      fault_q <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ret_q   <= ret_d;
      rem_q   <= rem_d;
      rst_q   <= rst_d;
      en_q    <= en_d;
      pd_n_q  <= pd_n_d;
      ready_q <= ready_d;
      lost_q  <= lost_d;
      fault_q <= fault_d;
      loss_q  <= loss_d;
    end
  end

  assign pll_powerdown_n_o = pd_n_q;
  assign pll_out_en_o      = en_q;
  assign domain_reset_o    = rst_q;
  assign ready_o           = ready_q;
  assign lock_lost_o       = lost_q;
  assign fault_o           = fault_q;
  assign loss_count_o      = loss_q;

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// tb/tb_pll_lock_reset_sequencer.sv - self-checking bench for pll_lock_reset_sequencer
module tb_pll_lock_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       lock;
  logic [3:0] mask;
  logic       clr;
  logic       pd_n;
  logic [3:0] en;
  logic [3:0] drst;
  logic       ready;
  logic       lost;
  logic       fault;
  logic [7:0] loss;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pll_lock_reset_sequencer #(
    .NUM_OUT      (4),
    .PD_CYCLES    (4),
    .LOCK_TIMEOUT (20),
    .LOCK_FILTER  (8),
    .RELEASE_GAP  (3),
    .MAX_RETRIES  (1),
    .CNT_W        (17)
  ) dut (
    .ref_clk_i         (clk),
    .reset_i           (rst),
    .pll_lock_i        (lock),
    .out_en_mask_i     (mask),
    .clear_fault_i     (clr),
    .pll_powerdown_n_o (pd_n),
    .pll_out_en_o      (en),
    .domain_reset_o    (drst),
    .ready_o           (ready),
    .lock_lost_o       (lost),
    .fault_o           (fault),
    .loss_count_o      (loss)
  );

  typedef struct {
    logic       lock;
    int         ncyc;
    logic       pd_n;
    logic [3:0] en;
    logic [3:0] rst;
    logic       ready;
  } vec_t;

  vec_t tbl[12];

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {20'd0, pd_n, en, drst, ready, fault, lost};
  endfunction

  function automatic logic [31:0] pk(input logic p, input logic [3:0] e, input logic [3:0] r,
                                     input logic rd, input logic f, input logic l);
    return {20'd0, p, e, r, rd, f, l};
  endfunction

  task automatic do_reset(input logic lk, input logic [3:0] m);
    lock = lk;
    mask = m;
    clr  = 1'b0;
    rst  = 1'b1;
    step(2);
    rst  = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b0,  3, 1'b0, 4'h0, 4'hF, 1'b0};
    tbl[1]  = '{1'b0,  1, 1'b1, 4'h0, 4'hF, 1'b0};
    tbl[2]  = '{1'b0,  4, 1'b1, 4'h0, 4'hF, 1'b0};
    tbl[3]  = '{1'b1, 10, 1'b1, 4'h0, 4'hF, 1'b0};
    tbl[4]  = '{1'b1,  1, 1'b1, 4'hF, 4'hF, 1'b0};
    tbl[5]  = '{1'b1,  3, 1'b1, 4'hF, 4'hF, 1'b0};
    tbl[6]  = '{1'b1,  1, 1'b1, 4'hF, 4'hE, 1'b0};
    tbl[7]  = '{1'b1,  2, 1'b1, 4'hF, 4'hE, 1'b0};
    tbl[8]  = '{1'b1,  1, 1'b1, 4'hF, 4'hC, 1'b0};
    tbl[9]  = '{1'b1,  3, 1'b1, 4'hF, 4'h8, 1'b0};
    tbl[10] = '{1'b1,  3, 1'b1, 4'hF, 4'h0, 1'b1};
    tbl[11] = '{1'b1,  5, 1'b1, 4'hF, 4'h0, 1'b1};

    // Normal bring-up, table driven from reset release.
    do_reset(1'b0, 4'hF);
    chk("reset_outputs", {obs(), loss}, {pk(1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0), 8'd0});
    for (int i = 0; i < 12; i++) begin
      lock = tbl[i].lock;
      step(tbl[i].ncyc);
      chk($sformatf("bringup_vec%0d", i), obs(),
          pk(tbl[i].pd_n, tbl[i].en, tbl[i].rst, tbl[i].ready, 1'b0, 1'b0));
    end
    chk("bringup_loss_count", loss, 0);

    // One-cycle lock drop in RUN: full loss three edges later, then re-sequence.
    lock = 1'b0;
    step(1);
    chk("loss_e1", obs(), pk(1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0));
    lock = 1'b1;
    step(1);
    chk("loss_e2", obs(), pk(1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0));
    step(1);
    chk("loss_e3", {obs(), loss}, {pk(1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 1'b1), 8'd1});
    step(1);
    chk("loss_pulse_end", obs(), pk(1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0));
    step(20);
    chk("reseq_before_run", obs(), pk(1'b1, 4'hF, 4'h8, 1'b0, 1'b0, 1'b0));
    step(1);
    chk("reseq_run", {obs(), loss}, {pk(1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0), 8'd1});

    // Lock never arrives: one retry, then fault; clear_fault restarts power-down.
    do_reset(1'b0, 4'hF);
    step(23);
    chk("to_wait_end", obs(), pk(1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0));
    step(1);
    chk("to_retry_pd_start", pd_n, 0);
    step(3);
    chk("to_retry_pd_last", pd_n, 0);
    step(1);
    chk("to_retry_pd_end", pd_n, 1);
    step(19);
    chk("to_second_wait", obs(), pk(1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0));
    step(1);
    chk("to_fault", obs(), pk(1'b0, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0));
    step(10);
    chk("fault_held", obs(), pk(1'b0, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0));
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("fault_cleared", obs(), pk(1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0));
    step(4);
    chk("restart_wait", obs(), pk(1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0));

    // Lock chatter at filter count 5 restarts qualification.
    do_reset(1'b1, 4'hF);
    step(7);
    lock = 1'b0;
    step(1);
    lock = 1'b1;
    step(2);
    chk("chatter_back_to_wait", obs(), pk(1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0));
    step(3);
    chk("chatter_no_early_enable", en, 0);
    step(5);
    chk("chatter_filter_last", en, 0);
    step(1);
    chk("chatter_enable", obs(), pk(1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0));

    // Partial mask: only domains 1 and 3 released, three cycles apart.
    do_reset(1'b1, 4'b1010);
    step(13);
    chk("mask_enable", obs(), pk(1'b1, 4'hA, 4'hF, 1'b0, 1'b0, 1'b0));
    step(3);
    chk("mask_release_entry", drst, 4'hF);
    step(1);
    chk("mask_rel1", drst, 4'hD);
    step(2);
    chk("mask_gap", obs(), pk(1'b1, 4'hA, 4'hD, 1'b0, 1'b0, 1'b0));
    step(1);
    chk("mask_rel3_run", obs(), pk(1'b1, 4'hA, 4'h5, 1'b1, 1'b0, 1'b0));
    step(5);
    chk("mask_hold", obs(), pk(1'b1, 4'hA, 4'h5, 1'b1, 1'b0, 1'b0));

    // Loss counter saturation, then reset in the middle of RELEASE.
    do_reset(1'b1, 4'hF);
    step(13);
    for (int i = 0; i < 255; i++) begin
      lock = 1'b0;
      step(1);
      lock = 1'b1;
      step(2);
      if (i == 0) chk("sat_first_loss", {31'd0, lost}, 1);
      step(9);
    end
    chk("sat_count_255", loss, 255);
    lock = 1'b0;
    step(1);
    lock = 1'b1;
    step(2);
    chk("sat_pulse_256", {31'd0, lost}, 1);
    step(9);
    chk("sat_hold_255", loss, 255);
    step(7);
    chk("mid_release_two_done", obs(), pk(1'b1, 4'hF, 4'hC, 1'b0, 1'b0, 1'b0));
    rst = 1'b1;
    step(1);
    chk("mid_release_reset", {obs(), loss}, {pk(1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0), 8'd0});
    rst = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
